ham_mem_arbiter: RTL and testbench
==================================

// Module: ham_mem_arbiter
// PURPOSE
//  Shares the single dat_mem port between two requesters: port 0 = Hamming
//  encoder sequencer, port 1 = decoder/checker sequencer. Grants in bursts
//  (e.g. 2 reads + 2 writes per message), round-robin between ports, with a
//  burst-length cap so neither side starves. Sits between the sequencers and
//  dat_mem; drives write_en/raddr/waddr/data_in, and data_out fans back to both.
// PARAMETERS
//  W          8    data width of dat_mem words
//  AW         8    address width ($clog2(byte_count), byte_count=256)
//  MAX_BURST  4    max accesses per grant before forced hand-over (>=1)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  init_n     in   1   async active-low reset
//  req        in   2   per-port access request, held while burst in progress
//  last       in   2   marks current access as final of the burst
//  we         in   2   1 = write access, 0 = read access
//  addr0      in   AW  port-0 address (read or write)
//  addr1      in   AW  port-1 address
//  wdata0     in   W   port-0 write data
//  wdata1     in   W   port-1 write data
//  gnt        out  2   registered one-hot grant (00 = idle)
//  preempt    out  2   1-cycle pulse: port's burst was cut by MAX_BURST
//  busy       out  1   gnt != 0
//  mem_we     out  1   to dat_mem write_en
//  mem_raddr  out  AW  to dat_mem raddr
//  mem_waddr  out  AW  to dat_mem waddr
//  mem_din    out  W   to dat_mem data_in
// BEHAVIOUR
//  - Reset (init_n low, async): gnt=00, preempt=00, busy=0, rr pointer=port 0,
//    burst count=0. mem_* are combinational off gnt, so mem_we=0 immediately.
//  - States: IDLE (gnt=00), G0 (gnt=01), G1 (gnt=10).
//  - IDLE: if req!=0, next cycle grant port by rr pointer when both request,
//    else the lone requester. Latency req->gnt = 1 cycle.
//  - Access: a cycle with gnt[i]&req[i]. mem_raddr=mem_waddr=addr_i,
//    mem_din=wdata_i, mem_we=we[i]. Reads: dat_mem is combinational, so the
//    requester samples data_out in the same cycle. No access -> mem_we=0,
//    addrs=0, din=0.
//  - Burst count: cleared on new grant, +1 per access, saturates at MAX_BURST.
//  - Release at end of a cycle in Gi when any of:
//      a) access with last[i]=1;
//      b) req[i]=0 (abandoned burst, no access that cycle);
//      c) access brings count to MAX_BURST AND req of other port=1
//         -> preempt[i]=1 next cycle for exactly 1 cycle.
//    On release rr pointer -> other port. Next state: other port's G if it
//    requests (no idle bubble), else IDLE. Re-grant to the same port
//    requires a pass through IDLE (min 1 idle cycle).
//  - At MAX_BURST with other port idle: no preempt; keep grant, count holds.
//  - Granted cycle with last=1 and other port idle: -> IDLE.
//  - Non-granted port's inputs are ignored; never reaches dat_mem.
//  - Exactly one port ever drives dat_mem; gnt is never 11.
//  - Write to address hit by same-cycle read returns old data (dat_mem).
// TESTING
//  1 reset: init_n=0 mid-G0 write -> same cycle gnt=00, mem_we=0; release
//    -> IDLE, pointer=0.
//  2 single burst: req=01, port0 does 2 reads addr 0,1 then 2 writes
//    addr 30,31 (last on 4th) -> gnt=01 from cycle 1, mem_we=0,0,1,1,
//    then gnt=00.
//  3 contention: req=11 from IDLE -> gnt=01; after port0 last, gnt=10 next
//    cycle with no gap; second tie later -> port0 wins again only via rr.
//  4 cap: MAX_BURST=4, port0 issues 6 accesses w/o last, port1 requesting
//    -> gnt=10 after 4th access, preempt=01 one cycle; port0 resumes after.
//  5 cap, no contender: port0 6 accesses, req1=0 -> gnt stays 01, preempt=00.
//  6 abandon: port1 granted, drops req without last -> gnt=00 next cycle,
//    mem_we never asserted for port1 in that cycle.

Source files
------------

// File: rtl/ham_mem_arbiter.sv
// Two-port burst arbiter sharing the single dat_mem port between the
// Hamming encoder sequencer (port 0) and the decoder/checker sequencer
// (port 1). Round-robin between ports, with a burst-length cap that hands
// the port over when the other side is waiting.
module ham_mem_arbiter #(
    parameter int W         = 8,
    parameter int AW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic [1:0]    req,
    input  logic [1:0]    last,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    preempt,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [W-1:0]  mem_din
);

    localparam int             CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rr_ptr;
    logic          rr_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    preempt_next;
    logic          own;
    logic          own_req;
    logic          other_req;
    logic          release_now;

    // State register, round-robin pointer, burst counter and preempt pulse
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            count   <= '0;
            preempt <= 2'b00;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            count   <= count_next;
            preempt <= preempt_next;
        end
    end

    // Next-state decision: grant from idle, count accesses, decide release
    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        count_next   = count;
        preempt_next = 2'b00;
        own          = (state == G1);
        own_req      = req[own];
        other_req    = req[~own];
        release_now  = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (req == 2'b11) begin
                    state_next = rr_ptr ? G1 : G0;
                end else if (req[0]) begin
                    state_next = G0;
                end else if (req[1]) begin
                    state_next = G1;
                end
            end
            G0, G1: begin
                if (!own_req) begin
                    release_now = 1'b1;
                end else begin
                    count_next = (count == MAX_CNT) ? count : count + CW'(1);
                    if (last[own]) begin
                        release_now = 1'b1;
                    end else if ((count_next == MAX_CNT) && other_req) begin
                        release_now       = 1'b1;
                        preempt_next[own] = 1'b1;
                    end
                end
                if (release_now) begin
                    rr_ptr_next = ~own;
                    count_next  = '0;
                    if (other_req) begin
                        state_next = own ? G0 : G1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant and busy decoded straight from the state register
    always_comb begin
        gnt = 2'b00;
        if (state == G0) begin
            gnt = 2'b01;
        end else if (state == G1) begin
            gnt = 2'b10;
        end
        busy = (gnt != 2'b00);
    end

    // Memory port mux: only a granted port that is requesting reaches dat_mem
    always_comb begin
        mem_we    = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_din   = '0;
        if ((state == G0) && req[0]) begin
            mem_we    = we[0];
            mem_raddr = addr0;
            mem_waddr = addr0;
            mem_din   = wdata0;
        end else if ((state == G1) && req[1]) begin
            mem_we    = we[1];
            mem_raddr = addr1;
            mem_waddr = addr1;
            mem_din   = wdata1;
        end
    end

endmodule

// File: tb/tb_ham_mem_arbiter.sv
// Directed-vector bench for ham_mem_arbiter: reset, single burst,
// contention with round-robin, burst cap with and without contender,
// and abandoned bursts.
module tb_ham_mem_arbiter;

    localparam int W         = 8;
    localparam int AW        = 8;
    localparam int MAX_BURST = 4;

    logic          clk;
    logic          init_n;
    logic [1:0]    req;
    logic [1:0]    last;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [W-1:0]  wdata0;
    logic [W-1:0]  wdata1;
    logic [1:0]    gnt;
    logic [1:0]    preempt;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_din;

    int vec_count;
    int miscompares;

    ham_mem_arbiter #(.W(W), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .init_n    (init_n),
        .req       (req),
        .last      (last),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .preempt   (preempt),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_din   (mem_din)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge, then let it settle
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk);
        #1;
        req    = r;
        last   = l;
        we     = w;
        addr0  = a0;
        addr1  = a1;
        wdata0 = d0;
        wdata1 = d1;
        #2;
    endtask

    // Directed test sequence
    initial begin
        vec_count   = 0;
        miscompares = 0;
        init_n = 1'b0;
        req    = 2'b00;
        last   = 2'b00;
        we     = 2'b00;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_gnt", {6'd0, gnt}, 8'h00);
        checkOutput("rst_preempt", {6'd0, preempt}, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("rst_we", {7'd0, mem_we}, 8'h00);
        @(negedge clk);
        init_n = 1'b1;

        // Contention: tie from idle goes to port 0, hand-over without a gap
        applyStimulus(2'b11, 2'b00, 2'b00, 8'd5, 8'd6, 8'h00, 8'h00);
        checkOutput("c_idle_gnt", {6'd0, gnt}, 8'h00);
        applyStimulus(2'b11, 2'b01, 2'b00, 8'd5, 8'd6, 8'h00, 8'h00);
        checkOutput("c_g0_gnt", {6'd0, gnt}, 8'h01);
        checkOutput("c_g0_raddr", mem_raddr, 8'd5);
        applyStimulus(2'b10, 2'b10, 2'b10, 8'd7, 8'd8, 8'h99, 8'h3c);
        checkOutput("c_g1_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("c_g1_we", {7'd0, mem_we}, 8'h01);
        checkOutput("c_g1_waddr", mem_waddr, 8'd8);
        checkOutput("c_g1_din", mem_din, 8'h3c);
        applyStimulus(2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'h00, 8'h00);
        checkOutput("c_idle2_gnt", {6'd0, gnt}, 8'h00);
        applyStimulus(2'b11, 2'b01, 2'b00, 8'd1, 8'd2, 8'h00, 8'h00);
        checkOutput("c_tie2_gnt", {6'd0, gnt}, 8'h01);
        applyStimulus(2'b10, 2'b10, 2'b00, 8'd0, 8'd9, 8'h00, 8'h00);
        checkOutput("c_g1b_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("c_g1b_raddr", mem_raddr, 8'd9);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("c_end_gnt", {6'd0, gnt}, 8'h00);

        // Single burst: 2 reads then 2 writes, last on the 4th access
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("s_idle_gnt", {6'd0, gnt}, 8'h00);
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("s_r0_gnt", {6'd0, gnt}, 8'h01);
        checkOutput("s_r0_we", {7'd0, mem_we}, 8'h00);
        checkOutput("s_r0_busy", {7'd0, busy}, 8'h01);
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 8'h00, 8'h00);
        checkOutput("s_r1_raddr", mem_raddr, 8'd1);
        checkOutput("s_r1_we", {7'd0, mem_we}, 8'h00);
        applyStimulus(2'b01, 2'b00, 2'b01, 8'd30, 8'd0, 8'haa, 8'h00);
        checkOutput("s_w0_we", {7'd0, mem_we}, 8'h01);
        checkOutput("s_w0_waddr", mem_waddr, 8'd30);
        checkOutput("s_w0_din", mem_din, 8'haa);
        applyStimulus(2'b01, 2'b01, 2'b01, 8'd31, 8'd0, 8'h55, 8'h00);
        checkOutput("s_w1_we", {7'd0, mem_we}, 8'h01);
        checkOutput("s_w1_waddr", mem_waddr, 8'd31);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("s_end_gnt", {6'd0, gnt}, 8'h00);
        checkOutput("s_end_we", {7'd0, mem_we}, 8'h00);

        // Async reset mid-write; pointer was at port 1 and must return to 0
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        applyStimulus(2'b01, 2'b00, 2'b01, 8'd40, 8'd0, 8'h77, 8'h00);
        checkOutput("r_pre_we", {7'd0, mem_we}, 8'h01);
        init_n = 1'b0;
        #1;
        checkOutput("r_async_gnt", {6'd0, gnt}, 8'h00);
        checkOutput("r_async_we", {7'd0, mem_we}, 8'h00);
        checkOutput("r_async_busy", {7'd0, busy}, 8'h00);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        init_n = 1'b1;
        applyStimulus(2'b11, 2'b00, 2'b00, 8'd1, 8'd2, 8'h00, 8'h00);
        checkOutput("r_idle_gnt", {6'd0, gnt}, 8'h00);
        applyStimulus(2'b11, 2'b01, 2'b00, 8'd1, 8'd2, 8'h00, 8'h00);
        checkOutput("r_ptr0_gnt", {6'd0, gnt}, 8'h01);
        applyStimulus(2'b00, 2'b00, 2'b10, 8'd0, 8'd2, 8'h00, 8'h00);
        checkOutput("r_g1_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("r_g1_we", {7'd0, mem_we}, 8'h00);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("r_end_gnt", {6'd0, gnt}, 8'h00);

        // Burst cap with a contender: hand-over after 4 accesses plus preempt pulse
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd10, 8'd0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b00, 2'b00, 8'(10 + i), 8'd20, 8'h00, 8'h00);
            checkOutput("p_g0_gnt", {6'd0, gnt}, 8'h01);
            checkOutput("p_g0_raddr", mem_raddr, 8'(10 + i));
            checkOutput("p_g0_preempt", {6'd0, preempt}, 8'h00);
        end
        applyStimulus(2'b11, 2'b10, 2'b00, 8'd14, 8'd20, 8'h00, 8'h00);
        checkOutput("p_g1_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("p_g1_preempt", {6'd0, preempt}, 8'h01);
        checkOutput("p_g1_raddr", mem_raddr, 8'd20);
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd14, 8'd0, 8'h00, 8'h00);
        checkOutput("p_res_gnt", {6'd0, gnt}, 8'h01);
        checkOutput("p_res_preempt", {6'd0, preempt}, 8'h00);
        checkOutput("p_res_raddr", mem_raddr, 8'd14);
        applyStimulus(2'b01, 2'b01, 2'b00, 8'd15, 8'd0, 8'h00, 8'h00);
        checkOutput("p_res2_raddr", mem_raddr, 8'd15);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("p_end_gnt", {6'd0, gnt}, 8'h00);

        // Burst cap with no contender: grant holds for all 6 accesses
        applyStimulus(2'b01, 2'b00, 2'b00, 8'd50, 8'd0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b01, (i == 5) ? 2'b01 : 2'b00, 2'b01, 8'(50 + i), 8'd0, 8'(i), 8'h00);
            checkOutput("n_gnt", {6'd0, gnt}, 8'h01);
            checkOutput("n_preempt", {6'd0, preempt}, 8'h00);
            checkOutput("n_waddr", mem_waddr, 8'(50 + i));
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("n_end_gnt", {6'd0, gnt}, 8'h00);
        checkOutput("n_end_preempt", {6'd0, preempt}, 8'h00);

        // Abandoned burst: port 1 drops req without last, no write reaches memory
        applyStimulus(2'b10, 2'b00, 2'b00, 8'd0, 8'd60, 8'h00, 8'h00);
        applyStimulus(2'b10, 2'b00, 2'b10, 8'd0, 8'd60, 8'h00, 8'h11);
        checkOutput("a_g1_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("a_g1_we", {7'd0, mem_we}, 8'h01);
        applyStimulus(2'b00, 2'b00, 2'b10, 8'd0, 8'd61, 8'h00, 8'h22);
        checkOutput("a_drop_gnt", {6'd0, gnt}, 8'h02);
        checkOutput("a_drop_we", {7'd0, mem_we}, 8'h00);
        checkOutput("a_drop_waddr", mem_waddr, 8'd0);
        checkOutput("a_drop_din", mem_din, 8'h00);
        applyStimulus(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        checkOutput("a_end_gnt", {6'd0, gnt}, 8'h00);
        checkOutput("a_end_busy", {7'd0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
